tone_param_bank: RTL and testbench
==================================

# tone_param_bank

Double-buffered parameter bank that sits directly downstream of the AXI-Stream command decoder. It consumes the decoder's write pulses (index, gain, safe, commit) into a shadow bank of 2 channels × 8 tones. On a gated commit it transfers the whole shadow bank atomically into the active bank at the next frame boundary. The active bank drives the tone generators, so parameter changes never tear mid-frame.

## Interface
- IDX_W, 10, tone table index width
- GAIN_W, 18, gain width (Q1.17)
- GAIN_RST, 18'h20000, reset gain for every tone (1.0 in Q1.17)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- idx_we  in  1  one-cycle pulse: write wr_index to shadow[wr_ch][wr_tone]
- gain_we  in  1  one-cycle pulse: write wr_gain to shadow[wr_ch][wr_tone]
- wr_ch  in  1  channel select, 0=A, 1=B
- wr_tone  in  3  tone select 0..7
- wr_index  in  IDX_W  index payload
- wr_gain  in  GAIN_W  gain payload
- commit_req  in  1  one-cycle commit request pulse
- safe_we  in  1  one-cycle pulse: load safe_val into safe register
- safe_val  in  1  1=commits allowed, 0=commits blocked
- frame_tick  in  1  one-cycle frame-boundary strobe from the synth timing block
- act_index  out  16*IDX_W  active indices, slot s = ch*8+tone at [s*IDX_W +: IDX_W]
- act_gain  out  16*GAIN_W  active gains, same slot packing
- safe_en  out  1  current safe register
- commit_pending  out  1  commit armed, waiting for frame_tick
- commit_done  out  1  one-cycle pulse on the cycle the active bank has just been updated
- commit_blocked  out  1  one-cycle pulse when a commit is refused or cancelled
- shadow_dirty  out  1  shadow differs from active by at least one write since the last apply

## Operation
- Reset: shadow and active indices 0, gains GAIN_RST; safe_en 0; commit_pending 0; commit_done 0; commit_blocked 0; shadow_dirty 0. Reset mid-operation aborts any pending commit immediately.
- Shadow writes:
  - idx_we and gain_we are independent.
  - If both are asserted in the same cycle, both fields of the addressed slot are written.
  - Any write sets shadow_dirty.
  - Writes never touch the active bank directly.
- Safe: safe_we loads safe_val into safe_en. safe_en=0 while pending cancels the pending commit and pulses commit_blocked.
- FSM states: IDLE, PENDING, APPLY.
  - IDLE: on commit_req with safe_en=1, go to PENDING. If frame_tick is also asserted that cycle, go straight to APPLY. On commit_req with safe_en=0, pulse commit_blocked and stay in IDLE.
  - PENDING: on frame_tick, go to APPLY. On safe_en==0, return to IDLE and pulse commit_blocked. A further commit_req is coalesced (no effect).
  - APPLY: lasts one cycle. Copies all 16 shadow slots into the active bank, pulses commit_done, clears shadow_dirty, then returns to IDLE. A commit_req in APPLY re-arms PENDING.
- safe_en uses the registered value. A safe_we and a commit_req in the same cycle evaluate commit_req against the old safe_en.
- Apply with a concurrent shadow write in the same cycle:
  - The active bank receives the pre-write shadow value.
  - The new write lands in the shadow only.
  - shadow_dirty stays 1.
- Commit with shadow_dirty=0 still executes (harmless copy) and pulses commit_done.
- All outputs are registered. No arithmetic, and no width conversion beyond the packing above.

## Timing
- Shadow write: pulse in cycle N; shadow updated at the N+1 edge; shadow_dirty=1 from N+1.
- Commit armed: commit_req in cycle N; commit_pending=1 from N+1.
- Apply:
  - frame_tick in cycle M while PENDING; FSM in APPLY during M+1.
  - act_index, act_gain, and commit_done (high for exactly one cycle) update at the M+2 edge.
  - commit_pending drops at M+2.
- Same-cycle commit_req and frame_tick from IDLE: APPLY in N+1; outputs at N+2.
- commit_blocked is asserted the cycle after the cause and lasts one cycle.
- Inputs are never backpressured. Every pulse is honoured in the cycle it arrives.

## Test plan
- Reset: assert rst_n=0 mid-PENDING -> all outputs at reset values; act_gain slots = 18'h20000; no commit_done afterward.
- Blocked commit: safe_en=0, commit_req -> commit_blocked 1 cycle later, commit_pending stays 0, active unchanged.
- Normal commit: safe=1; write idx ch1/tone5=0x3A7 and gain=0x1FFFF; commit_req; frame_tick 4 cycles later -> slot 13 active index 0x3A7 and gain 0x1FFFF, exactly 2 cycles after frame_tick; commit_done single pulse; shadow_dirty=0.
- Cancel: arm commit, then safe_we with val=0 before frame_tick -> commit_blocked pulse, returns to IDLE, next frame_tick does nothing.
- Race: idx write to ch0/tone0=0x055 in the APPLY cycle -> active slot 0 keeps the old value; shadow_dirty=1; a second commit applies 0x055.
- Coalesce: three commit_req while PENDING plus one frame_tick -> exactly one commit_done.

Source files
------------

// File: rtl/tone_param_bank.sv
// tone_param_bank: double-buffered 2x8 tone parameter bank with frame-aligned atomic commit
module tone_param_bank #(
  parameter int                IDX_W    = 10,
  parameter int                GAIN_W   = 18,
  parameter logic [GAIN_W-1:0] GAIN_RST = 18'h20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 idx_we,
  input  logic                 gain_we,
  input  logic                 wr_ch,
  input  logic [2:0]           wr_tone,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [GAIN_W-1:0]    wr_gain,
  input  logic                 commit_req,
  input  logic                 safe_we,
  input  logic                 safe_val,
  input  logic                 frame_tick,
  output logic [16*IDX_W-1:0]  act_index,
  output logic [16*GAIN_W-1:0] act_gain,
  output logic                 safe_en,
  output logic                 commit_pending,
  output logic                 commit_done,
  output logic                 commit_blocked,
  output logic                 shadow_dirty
);
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t                state_q, state_d;
  logic [16*IDX_W-1:0]   sh_index_q, sh_index_d, act_index_q, act_index_d;
  logic [16*GAIN_W-1:0]  sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;
  logic                  safe_en_q, safe_en_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic                  blocked_q, blocked_d;
  logic                  dirty_q, dirty_d;
  logic [3:0]            slot;
  logic                  apply;

  assign slot           = {wr_ch, wr_tone};
  assign apply          = state_q == APPLY;
  assign act_index      = act_index_q;
  assign act_gain       = act_gain_q;
  assign safe_en        = safe_en_q;
  assign commit_pending = pending_q;
  assign commit_done    = done_q;
  assign commit_blocked = blocked_q;
  assign shadow_dirty   = dirty_q;

  // Shadow writes land independently; apply copies the pre-write shadow into the active bank
  always_comb begin
    sh_index_d = sh_index_q;
    sh_gain_d  = sh_gain_q;
    if (idx_we) sh_index_d[slot*IDX_W +: IDX_W] = wr_index;
    if (gain_we) sh_gain_d[slot*GAIN_W +: GAIN_W] = wr_gain;
    act_index_d = apply ? sh_index_q : act_index_q;
    act_gain_d  = apply ? sh_gain_q : act_gain_q;
    dirty_d     = (idx_we || gain_we) ? 1'b1 : (apply ? 1'b0 : dirty_q);
    safe_en_d   = safe_we ? safe_val : safe_en_q;
  end

  // Commit FSM: arm on a safe request, apply on the frame boundary, cancel if safe drops
  always_comb begin
    state_d   = state_q;
    blocked_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req && safe_en_q) state_d = frame_tick ? APPLY : PENDING;
        blocked_d = commit_req && !safe_en_q;
      end
      PENDING: begin
        state_d   = !safe_en_q ? IDLE : (frame_tick ? APPLY : PENDING);
        blocked_d = !safe_en_q;
      end
      APPLY:   state_d = commit_req ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = state_d != IDLE;
    done_d    = apply;
  end

  // State and bank registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_index_q  <= '0;
      sh_gain_q   <= {16{GAIN_RST}};
      act_index_q <= '0;
      act_gain_q  <= {16{GAIN_RST}};
      safe_en_q   <= 1'b0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      blocked_q   <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_index_q  <= sh_index_d;
      sh_gain_q   <= sh_gain_d;
      act_index_q <= act_index_d;
      act_gain_q  <= act_gain_d;
      safe_en_q   <= safe_en_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      blocked_q   <= blocked_d;
      dirty_q     <= dirty_d;
    end
  end
endmodule

// File: tb/tb_tone_param_bank.sv
// tb_tone_param_bank: directed self-checking bench for tone_param_bank
module tb_tone_param_bank;
  logic         clk = 0, rst_n = 0;
  logic         idx_we = 0, gain_we = 0, wr_ch = 0, commit_req = 0, safe_we = 0, safe_val = 0, frame_tick = 0;
  logic [2:0]   wr_tone = 0;
  logic [9:0]   wr_index = 0;
  logic [17:0]  wr_gain = 0;
  logic [159:0] act_index;
  logic [287:0] act_gain;
  logic         safe_en, commit_pending, commit_done, commit_blocked, shadow_dirty;
  logic [159:0] exp_i;
  logic [287:0] exp_g, rst_g;
  int           n_vec = 0, n_err = 0, n_done = 0;

  tone_param_bank dut (
    .clk(clk), .rst_n(rst_n), .idx_we(idx_we), .gain_we(gain_we), .wr_ch(wr_ch), .wr_tone(wr_tone),
    .wr_index(wr_index), .wr_gain(wr_gain), .commit_req(commit_req), .safe_we(safe_we), .safe_val(safe_val),
    .frame_tick(frame_tick), .act_index(act_index), .act_gain(act_gain), .safe_en(safe_en),
    .commit_pending(commit_pending), .commit_done(commit_done), .commit_blocked(commit_blocked),
    .shadow_dirty(shadow_dirty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    idx_we = 0; gain_we = 0; commit_req = 0; safe_we = 0; frame_tick = 0;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic ch, input logic [2:0] t, input logic ie, input logic [9:0] iv, input logic ge, input logic [17:0] gv);
    wr_ch = ch; wr_tone = t; idx_we = ie; wr_index = iv; gain_we = ge; wr_gain = gv;
  endtask

  initial begin
    rst_g = {16{18'h20000}};
    exp_i = '0;
    exp_g = rst_g;
    step(); step();
    rst_n = 1;
    step();
    chk("rst_idx", act_index, '0);
    chk("rst_gain", act_gain, rst_g);
    chk("rst_flags", {safe_en, commit_pending, commit_done, commit_blocked, shadow_dirty}, 5'b0);
    // blocked commit
    commit_req = 1;
    step();
    chk("blk_pulse", commit_blocked, 1);
    chk("blk_pend", commit_pending, 0);
    step();
    chk("blk_end", commit_blocked, 0);
    chk("blk_act", act_index, exp_i);
    // normal commit
    safe_we = 1; safe_val = 1;
    step();
    chk("safe_on", safe_en, 1);
    wr(1, 5, 1, 10'h3A7, 1, 18'h1FFFF);
    step();
    chk("nrm_dirty", shadow_dirty, 1);
    chk("nrm_act_untouched", act_index, exp_i);
    commit_req = 1;
    step();
    chk("nrm_pend", commit_pending, 1);
    step(); step();
    frame_tick = 1;
    step();
    chk("nrm_m1_done", commit_done, 0);
    chk("nrm_m1_act", act_index, exp_i);
    chk("nrm_m1_pend", commit_pending, 1);
    step();
    exp_i[13*10 +: 10] = 10'h3A7;
    exp_g[13*18 +: 18] = 18'h1FFFF;
    chk("nrm_idx", act_index, exp_i);
    chk("nrm_gain", act_gain, exp_g);
    chk("nrm_done", commit_done, 1);
    chk("nrm_pend_drop", commit_pending, 0);
    chk("nrm_dirty_clr", shadow_dirty, 0);
    step();
    chk("nrm_done_1cyc", commit_done, 0);
    // cancel
    commit_req = 1;
    step();
    chk("cxl_pend", commit_pending, 1);
    safe_we = 1; safe_val = 0;
    step();
    chk("cxl_safe_off", safe_en, 0);
    step();
    chk("cxl_blk", commit_blocked, 1);
    chk("cxl_pend_drop", commit_pending, 0);
    step();
    chk("cxl_blk_end", commit_blocked, 0);
    frame_tick = 1;
    step(); step();
    chk("cxl_no_done", commit_done, 0);
    chk("cxl_act", act_index, exp_i);
    // race: write during APPLY
    safe_we = 1; safe_val = 1;
    step();
    commit_req = 1; frame_tick = 1;
    step();
    chk("race_pend", commit_pending, 1);
    wr(0, 0, 1, 10'h055, 0, 18'h0);
    step();
    chk("race_done", commit_done, 1);
    chk("race_act_old", act_index, exp_i);
    chk("race_dirty", shadow_dirty, 1);
    commit_req = 1;
    step();
    frame_tick = 1;
    step(); step();
    exp_i[9:0] = 10'h055;
    chk("race_done2", commit_done, 1);
    chk("race_act_new", act_index, exp_i);
    chk("race_gain", act_gain, exp_g);
    chk("race_dirty_clr", shadow_dirty, 0);
    // coalesce: arm, three more requests while pending, one tick
    commit_req = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      commit_req = 1;
      step();
    end
    chk("coal_pend", commit_pending, 1);
    frame_tick = 1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_done += int'(commit_done);
    end
    chk("coal_done_cnt", n_done, 1);
    chk("coal_pend_end", commit_pending, 0);
    // reset while pending
    wr(1, 7, 1, 10'h2AA, 1, 18'h00123);
    commit_req = 1;
    step();
    chk("rstp_pend", commit_pending, 1);
    #3 rst_n = 0;
    #1;
    chk("rstp_idx", act_index, '0);
    chk("rstp_gain", act_gain, rst_g);
    chk("rstp_flags", {safe_en, commit_pending, commit_done, commit_blocked, shadow_dirty}, 5'b0);
    @(negedge clk);
    rst_n = 1;
    frame_tick = 1;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_done += int'(commit_done);
    end
    chk("rstp_no_done", n_done, 0);
    chk("rstp_idx_hold", act_index, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
